// File: rtl/conway_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conway_pkg                                                           |
// | Shared grid geometry and reader FSM encoding for the Conway display. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package conway_pkg;

  localparam int WORD_BITS     = 20;
  localparam int WORDS_PER_ROW = 64;
  localparam int ROWS          = 1024;
  localparam int GRID_WIDTH    = WORD_BITS * WORDS_PER_ROW;
  localparam int GRID_HEIGHT   = ROWS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } reader_state_e;

endpackage
`default_nettype wire

// File: rtl/conway_word_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conway_word_fifo                                                     |
// | Small prefetch FIFO for grid words; push and pop may coincide when   |
// | full.                                                                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module conway_word_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = conway_pkg::WORD_BITS,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);
  import conway_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_pop   = pop && (count_q != '0) && !clear;
    // A full FIFO still accepts a word when one leaves in the same cycle.
    do_push  = push && ((count_q < CNT_W'(DEPTH)) || do_pop) && !clear;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
    if (do_push && !reset) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule
`default_nettype wire

// File: rtl/conway_vga_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conway_vga_reader                                                    |
// | Streams one frame of grid cells from the accelerator display port    |
// | as a valid/ready pixel stream, MSB (leftmost cell) first.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module conway_vga_reader #(
  parameter int WORD_BITS     = conway_pkg::WORD_BITS,
  parameter int WORDS_PER_ROW = conway_pkg::WORDS_PER_ROW,
  parameter int ROWS          = conway_pkg::ROWS,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  output logic [15:0]          address_b,
  input  logic [WORD_BITS-1:0] q_b,
  input  logic                 wait_request,
  output logic                 ready_sig,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 pix_alive,
  output logic                 pix_eol,
  output logic                 pix_last
);
  import conway_pkg::*;

  localparam int TOTAL_WORDS = ROWS * WORDS_PER_ROW;
  localparam int GRID_W      = WORD_BITS * WORDS_PER_ROW;
  localparam int ISS_W       = $clog2(TOTAL_WORDS + 1);
  localparam int X_W         = $clog2(GRID_W);
  localparam int Y_W         = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int BIT_W       = $clog2(WORD_BITS);
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);

  reader_state_e        state_q, state_d;
  logic [15:0]          addr_q, addr_d;
  logic [ISS_W-1:0]     issued_q, issued_d;
  logic                 inflight_q, inflight_d;
  logic [WORD_BITS-1:0] word_q, word_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 valid_q, valid_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;

  logic                 fifo_clear, fifo_push, fifo_pop;
  logic [WORD_BITS-1:0] fifo_rd_data;
  logic [CNT_W-1:0]     fifo_count;
  logic [CNT_W:0]       occupancy;
  logic                 xfer, issue, load, last_bit, at_eol, at_last;

  conway_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (q_b),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .count     (fifo_count)
  );

  assign xfer      = valid_q & pix_ready;
  assign last_bit  = (bit_q == BIT_W'(WORD_BITS - 1));
  assign at_eol    = (x_q == X_W'(GRID_W - 1));
  assign at_last   = at_eol && (y_q == Y_W'(ROWS - 1));
  // Reads still in flight count against FIFO space so a capture never overflows.
  assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    issued_d   = issued_q;
    inflight_d = 1'b0;
    word_d     = word_q;
    bit_d      = bit_q;
    valid_d    = valid_q;
    x_d        = x_q;
    y_d        = y_q;
    fifo_clear = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    issue      = 1'b0;
    load       = 1'b0;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (frame_start) begin
          state_d    = STREAM;
          addr_d     = '0;
          issued_d   = '0;
          word_d     = '0;
          bit_d      = '0;
          x_d        = '0;
          y_d        = '0;
          fifo_clear = 1'b1;
        end
      end
      STREAM: begin
        issue      = !wait_request && (issued_q < ISS_W'(TOTAL_WORDS)) &&
                     (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
        fifo_push  = inflight_q;
        inflight_d = issue;
        if (issue) begin
          issued_d = issued_q + ISS_W'(1);
          if (addr_q != 16'hFFFF) addr_d = addr_q + 16'd1;
        end
        load = (fifo_count != '0) && (!valid_q || (xfer && last_bit));
        if (xfer) begin
          if (at_eol) begin
            x_d = '0;
            y_d = at_last ? '0 : y_q + Y_W'(1);
          end else begin
            x_d = x_q + X_W'(1);
          end
        end
        if (load) begin
          word_d   = fifo_rd_data;
          bit_d    = '0;
          valid_d  = 1'b1;
          fifo_pop = 1'b1;
        end else if (xfer) begin
          if (last_bit) begin
            valid_d = 1'b0;
          end else begin
            word_d = word_q << 1;
            bit_d  = bit_q + BIT_W'(1);
          end
        end
        if (xfer && at_last) begin
          state_d = DONE;
          valid_d = 1'b0;
        end
      end
      DONE: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      word_q     <= '0;
      bit_q      <= '0;
      valid_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      word_q     <= word_d;
      bit_q      <= bit_d;
      valid_q    <= valid_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  assign address_b = addr_q;
  assign ready_sig = (state_q == IDLE);
  assign pix_valid = valid_q;
  assign pix_alive = word_q[WORD_BITS-1];
  assign pix_eol   = valid_q & at_eol;
  assign pix_last  = valid_q & at_last;

endmodule
`default_nettype wire

// File: tb/tb_conway_vga_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_conway_vga_reader                                                 |
// | Directed bench: synchronous memory model plus pixel scoreboard.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_conway_vga_reader;

  localparam int WB    = 20;
  localparam int WPR   = 64;
  localparam int ROWS  = 8;
  localparam int DEPTH = 2;
  localparam int GW    = WB * WPR;
  localparam int TW    = WPR * ROWS;
  localparam int TP    = GW * ROWS;
  localparam int AW    = $clog2(TW);

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic [15:0]   address_b;
  logic [WB-1:0] q_b;
  logic          wait_request;
  logic          ready_sig;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_alive;
  logic          pix_eol;
  logic          pix_last;

  logic [WB-1:0] mem [TW];

  int            n_checks = 0;
  int            n_fail   = 0;
  int            pix_idx;
  int            eol_cnt;
  int            cyc;
  int            first_cyc;
  int            last_cyc;
  int            fifo_max;
  bit            saw_last;
  bit            mon_en;
  bit            prev_stall;
  bit            rand_ready;
  logic [3:0]    snap;
  logic [WB-1:0] first_word;

  conway_vga_reader #(
    .WORD_BITS     (WB),
    .WORDS_PER_ROW (WPR),
    .ROWS          (ROWS),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .address_b    (address_b),
    .q_b          (q_b),
    .wait_request (wait_request),
    .ready_sig    (ready_sig),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_alive    (pix_alive),
    .pix_eol      (pix_eol),
    .pix_last     (pix_last)
  );

  always #5 clk = ~clk;

  // Accelerator display port: data for the address seen at the previous edge.
  always @(posedge clk) q_b <= mem[address_b[AW-1:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic [WB-1:0] w;
    logic [2:0]    exp_v;
    int            b;
    if (!mon_en) return;
    if (int'(dut.u_fifo.count) > fifo_max) fifo_max = int'(dut.u_fifo.count);
    if (prev_stall)
      check("stall_hold", 32'({pix_valid, pix_alive, pix_eol, pix_last}), 32'(snap));
    if (pix_valid && pix_ready) begin
      if (pix_idx >= TP) begin
        check("pixel_overrun", 32'(pix_idx), 32'(TP - 1));
      end else begin
        w     = mem[pix_idx / WB];
        b     = WB - 1 - (pix_idx % WB);
        exp_v = {w[b], (pix_idx % GW) == GW - 1, pix_idx == TP - 1};
        check("pixel", 32'({pix_alive, pix_eol, pix_last}), 32'(exp_v));
        if (pix_idx < WB) first_word[WB-1-pix_idx] = pix_alive;
        if (pix_idx == 0) first_cyc = cyc;
        if ((pix_idx % GW) == GW - 1) eol_cnt++;
        if (pix_idx == TP - 1) begin
          saw_last = 1'b1;
          last_cyc = cyc;
        end
      end
      pix_idx++;
    end
    prev_stall = pix_valid && !pix_ready;
    snap       = {pix_valid, pix_alive, pix_eol, pix_last};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rand_ready) pix_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    monitor();
  endtask

  task automatic start_frame();
    int lat;
    pix_idx     = 0;
    eol_cnt     = 0;
    saw_last    = 1'b0;
    prev_stall  = 1'b0;
    first_word  = '0;
    fifo_max    = 0;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    cyc++;
    @(negedge clk);
    check("start_addr", 32'(address_b), 32'h0);
    check("start_busy", 32'(ready_sig), 32'h0);
    lat = 0;
    while (!pix_valid && lat < 10) begin
      @(posedge clk);
      #1;
      cyc++;
      @(negedge clk);
      lat++;
    end
    check("first_valid_latency", 32'(lat), 32'd3);
    mon_en = 1'b1;
    monitor();
  endtask

  task automatic run_to_last(input int limit);
    int n;
    n = 0;
    while (!saw_last && n < limit) begin
      step();
      n++;
    end
    check("frame_completes", 32'(saw_last), 32'h1);
    step();
    check("done_not_ready", 32'(ready_sig), 32'h0);
    check("done_no_valid", 32'(pix_valid), 32'h0);
    step();
    check("idle_ready", 32'(ready_sig), 32'h1);
    check("frame_pixels", 32'(pix_idx), 32'(TP));
    check("frame_rows", 32'(eol_cnt), 32'(ROWS));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no summary expected summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] held;
    for (int i = 0; i < TW; i++) mem[i] = WB'($urandom);
    mem[0] = 20'h80001;
    reset = 1'b1; frame_start = 1'b0; wait_request = 1'b0; pix_ready = 1'b1;
    rand_ready = 1'b0; mon_en = 1'b0; cyc = 0; pix_idx = 0; eol_cnt = 0;
    saw_last = 1'b0; prev_stall = 1'b0; snap = '0; first_word = '0; fifo_max = 0;
    first_cyc = 0; last_cyc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr", 32'(address_b), 32'h0);
    check("rst_outputs", 32'({pix_valid, pix_alive, pix_eol, pix_last}), 32'h0);
    check("rst_ready", 32'(ready_sig), 32'h1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Full frame at one pixel per cycle; word 0 = 0x80001.
    start_frame();
    run_to_last(TP + 100);
    check("first_word", 32'(first_word), 32'h80001);
    check("contiguous_span", 32'(last_cyc - first_cyc), 32'(TP - 1));

    // Randomly stalled consumer.
    rand_ready = 1'b1;
    start_frame();
    run_to_last(TP * 4 + 1000);
    check("fifo_bound", 32'(fifo_max <= DEPTH), 32'h1);
    rand_ready = 1'b0;
    pix_ready  = 1'b1;

    // Port stalls while word 63 (end of row 0) is presented.
    start_frame();
    n = 0;
    while (address_b != 16'd63 && n < 3000) begin
      step();
      n++;
    end
    check("reach_word63", 32'(address_b), 32'd63);
    wait_request = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("addr_hold", 32'(address_b), 32'd63);
    end
    wait_request = 1'b0;
    run_to_last(TP + 1000);

    // Reset in the middle of row 5.
    start_frame();
    n = 0;
    while (pix_idx < 5 * GW + 700 && n < TP) begin
      step();
      n++;
    end
    check("reach_row5", 32'(pix_idx), 32'(5 * GW + 700));
    mon_en = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    #1 cyc++;
    @(negedge clk);
    check("midrst_addr", 32'(address_b), 32'h0);
    check("midrst_outputs", 32'({pix_valid, pix_alive, pix_eol, pix_last}), 32'h0);
    check("midrst_ready", 32'(ready_sig), 32'h1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // Restarted frame; frame_start pulsed mid-stream must be ignored.
    start_frame();
    n = 0;
    while (pix_idx < 3000 && n < TP) begin
      step();
      n++;
    end
    wait_request = 1'b1;
    step();
    held        = address_b;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("fs_ignored_addr", 32'(address_b), 32'(held));
    check("fs_ignored_busy", 32'(ready_sig), 32'h0);
    wait_request = 1'b0;
    run_to_last(TP + 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conway_vga_reader.md
CONWAY_VGA_READER -- requirements
Module: conway_vga_reader

Interface
REQ-001 Parameters SHALL be: WORD_BITS, default 20, cells per memory word; WORDS_PER_ROW, default 64, words per grid row; ROWS, default 1024, grid rows; FIFO_DEPTH, default 2, prefetched words.
REQ-002 Ports SHALL be:
- clk, in, 1, sole clock.
- reset, in, 1, synchronous active-high reset.
- frame_start, in, 1, request to display one frame.
- address_b, out, 16, display-port read address into the accelerator.
- q_b, in, 20, read data for the address presented on the previous edge.
- wait_request, in, 1, read not accepted this cycle.
- ready_sig, out, 1, display idle; the accelerator may swap buffers.
- pix_valid, out, 1, pixel available.
- pix_ready, in, 1, downstream consumes the pixel.
- pix_alive, out, 1, cell state of the current pixel.
- pix_eol, out, 1, current pixel is the last in its row.
- pix_last, out, 1, current pixel is the last in the frame.
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 FSM states SHALL be IDLE, STREAM and DONE; reset SHALL enter IDLE.
REQ-005 IDLE SHALL move to STREAM when frame_start=1; this SHALL clear the read address, pixel counters and FIFO.
REQ-006 frame_start SHALL be ignored in STREAM and DONE.
REQ-007 ready_sig SHALL be 1 in IDLE and 0 in STREAM and DONE.
REQ-008 A read SHALL issue in a STREAM cycle when wait_request=0, words issued < ROWS*WORDS_PER_ROW, and FIFO occupancy plus in-flight reads < FIFO_DEPTH.
REQ-009 address_b SHALL hold its value while wait_request=1; it SHALL increment by 1 only on an issued read; it SHALL never wrap past 65535.
REQ-010 q_b SHALL be captured on the edge after its read issues; a read issued while wait_request=1 is forbidden.
REQ-011 The serializer SHALL load a word from the FIFO when its bit index is 19 and the pixel transfers, or when it is empty.
REQ-012 The serializer SHALL output bit 19 first and bit 0 last; bit 19 is the leftmost cell of the word.
REQ-013 A transfer SHALL occur when pix_valid=1 and pix_ready=1.
REQ-014 While pix_valid=1 and pix_ready=0, pix_valid, pix_alive, pix_eol and pix_last SHALL stay stable.
REQ-015 Column counter x SHALL run 0..1279 and row counter y SHALL run 0..1023, advancing on transfers only.
REQ-016 pix_eol SHALL be 1 when x=1279; pix_last SHALL be 1 when x=1279 and y=1023.
REQ-017 With wait_request=0, first pix_valid SHALL assert exactly 3 cycles after the frame_start edge.
REQ-018 With pix_ready=1 and wait_request=0, the block SHALL sustain one pixel per cycle with no bubbles across word and row boundaries.
REQ-019 The pix_last transfer SHALL move the FSM to DONE for one cycle, then to IDLE.
REQ-020 pix_valid SHALL be 0 outside STREAM.

Reset
REQ-021 Reset SHALL set: address_b=0, pix_valid=0, pix_alive=0, pix_eol=0, pix_last=0, ready_sig=1, FSM=IDLE.
REQ-022 Reset mid-frame SHALL flush the FIFO and serializer, discard any in-flight read, and zero the counters.

Structure
REQ-023 The shared package conway_pkg SHALL hold WORD_BITS, WORDS_PER_ROW, ROWS, the grid width/height constants and the reader FSM state enum.
REQ-024 The word FIFO SHALL be one sub-module, conway_word_fifo: FIFO_DEPTH x 20, with push, pop and count, and simultaneous push/pop allowed when full.

Verification
REQ-025 Directed scenarios the bench SHALL cover:
- Reset, word0=0x80001, frame_start, pix_ready=1 -> pix_valid at cycle 3; pixels 0 and 19 alive=1; pixels 1..18 alive=0.
- Full frame, pix_ready=1, wait_request=0 -> 1,310,720 contiguous transfers; pix_eol on every 1280th; pix_last on the final one; ready_sig=1 two cycles later.
- pix_ready random 50% -> pixel sequence matches memory exactly; outputs stable while stalled; FIFO never overflows.
- wait_request=1 for 10 cycles at word 63 -> address_b holds 63; no skipped or duplicated word; row 0/1 boundary correct.
- Reset at pixel 700 of row 5 -> reset values next cycle; new frame_start restarts at address 0, x=0, y=0.
- frame_start pulsed during STREAM -> no effect on address or counters.
